// File: rtl/rom_download_loader_if.sv
// Bundles the ioctl download stream, the core-side ROM write port and loader status.
// The slave modport is the loader's view; master is the hps_io/core side.
interface rom_download_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        ce_core;
  logic [16:0] rom_addr;
  logic [7:0]  rom_do;
  logic        rom_wr;
  logic        rom_rd;
  logic        core_reset;
  logic        load_done;
  logic [17:0] byte_count;
  logic        addr_err;
  logic        overflow;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ce_core,
    input  ioctl_wait, rom_addr, rom_do, rom_wr, rom_rd, core_reset, load_done,
           byte_count, addr_err, overflow
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ce_core,
    output ioctl_wait, rom_addr, rom_do, rom_wr, rom_rd, core_reset, load_done,
           byte_count, addr_err, overflow
  );
endinterface

// File: rtl/rom_download_loader.sv
// Buffers hps_io download bytes in a small FIFO and replays them to the core's ROM
// port one per ce_core slot, holding the core in reset until the image has landed.
//
// state | meaning
// IDLE  | no download seen since reset; core held in reset
// LOAD  | download active; bytes pushed and replayed to the core
// DRAIN | download ended; FIFO and open write slot still emptying
// DONE  | image written; core released, load_done high
module rom_download_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter int unsigned ROM_BYTES  = 131072
) (
  input logic                   clk_sys,
  input logic                   reset_n,
  rom_download_loader_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_C  = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t        state, state_next;
  logic          enter_load, enter_done;

  logic          sel, sel_q, sel_rise, active;
  logic          push_req, push, pop, full, empty;

  logic [16:0]   mem_addr [FIFO_DEPTH];
  logic [7:0]    mem_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [16:0]   exp_addr;

  logic          ioctl_wait_q;
  logic [16:0]   rom_addr_q;
  logic [7:0]    rom_do_q;
  logic          rom_wr_q;
  logic          core_reset_q;
  logic          load_done_q;
  logic [17:0]   byte_count_q;
  logic          addr_err_q;
  logic          overflow_q;

  assign sel      = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign sel_rise = sel && !sel_q;
  assign active   = (state == LOAD) || (state == DRAIN);
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);

  // Out-of-range bytes never reach the FIFO; a full FIFO turns the push into a drop.
  assign push_req = (state == LOAD) && sel && bus.ioctl_wr &&
                    ({15'd0, bus.ioctl_addr} < ROM_BYTES);
  assign push     = push_req && !full;
  assign pop      = bus.ce_core && active && !empty;

  always_comb begin
    state_next = state;
    enter_load = 1'b0;
    enter_done = 1'b0;
    case (state)
      IDLE:  if (sel_rise) state_next = LOAD;
      LOAD:  if (!sel) state_next = DRAIN;
      DRAIN: begin
        if (sel_rise)                 state_next = LOAD;
        else if (empty && !rom_wr_q)  state_next = DONE;
      end
      DONE:  if (sel_rise) state_next = LOAD;
      default: state_next = IDLE;
    endcase
    enter_load = (state_next == LOAD) && (state != LOAD);
    enter_done = (state_next == DONE) && (state != DONE);
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sel_q <= 1'b0;
    end else begin
      state <= state_next;
      sel_q <= sel;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_addr[wr_ptr] <= bus.ioctl_addr;
      mem_data[wr_ptr] <= bus.ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ioctl_wait_q <= 1'b0;
      rom_addr_q   <= '0;
      rom_do_q     <= '0;
      rom_wr_q     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      // Raised one entry early so the byte hps_io sends during its reaction cycle still fits.
      ioctl_wait_q <= (count_next >= WAIT_C);
      if (pop) begin
        rom_addr_q <= mem_addr[rd_ptr];
        rom_do_q   <= mem_data[rd_ptr];
        rom_wr_q   <= 1'b1;
      end else if (bus.ce_core) begin
        rom_wr_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      byte_count_q <= '0;
      addr_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
      exp_addr     <= '0;
    end else if (enter_load) begin
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      byte_count_q <= '0;
      addr_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
      exp_addr     <= '0;
    end else begin
      if (pop) byte_count_q <= byte_count_q + 18'd1;
      if (push_req) begin
        if (bus.ioctl_addr != exp_addr) addr_err_q <= 1'b1;
        exp_addr <= bus.ioctl_addr + 17'd1;
      end
      if (push_req && full) overflow_q <= 1'b1;
      if (enter_done) begin
        load_done_q  <= 1'b1;
        core_reset_q <= 1'b0;
      end
    end
  end

  assign bus.ioctl_wait = ioctl_wait_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_do     = rom_do_q;
  assign bus.rom_wr     = rom_wr_q;
  assign bus.rom_rd     = active;
  assign bus.core_reset = core_reset_q;
  assign bus.load_done  = load_done_q;
  assign bus.byte_count = byte_count_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_rom_download_loader.sv
// Directed bench for rom_download_loader: table of whole-download scenarios plus
// hand-written sequences for the wait threshold and a mid-load reset.
module tb_rom_download_loader;
  logic clk_sys = 1'b0;
  logic reset_n;
  int   ce_period = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   slot_err = 0;

  always #5 clk_sys = ~clk_sys;

  rom_download_loader_if bus ();

  rom_download_loader #(
    .FIFO_DEPTH(4),
    .ROM_INDEX (8'd0),
    .ROM_BYTES (131072)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t drv_q[$];
  wr_t cap_q[$];

  typedef struct {
    logic [7:0] index;
    int         nbytes;
    int         skip_at;
    int         ce_load;
    int         ce_after;
    bit         honour;
    int         exp_writes;
    logic       exp_rd;
    logic       exp_done;
    logic       exp_err;
    bit         chk_err;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected event within bound", name);
  endtask

  // core-clock strobe: one cycle high every ce_period cycles, off when ce_period is 0
  initial begin
    int ce_cnt;
    ce_cnt = 0;
    bus.ce_core = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ce_period == 0) begin
        bus.ce_core = 1'b0;
        ce_cnt = 0;
      end else begin
        bus.ce_core = (ce_cnt == 0);
        ce_cnt = (ce_cnt >= ce_period - 1) ? 0 : ce_cnt + 1;
      end
    end
  end

  // A new slot opens exactly when rom_wr is high right after a ce_core edge;
  // rom_wr may only change on ce_core edges (or reset).
  initial begin
    logic prev_wr;
    prev_wr = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset_n && !bus.ce_core && (bus.rom_wr !== prev_wr)) slot_err++;
      if (bus.ce_core && bus.rom_wr) cap_q.push_back('{bus.rom_addr, bus.rom_do});
      prev_wr = bus.rom_wr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_rom_addr"},   bus.rom_addr,   0);
    check({tag, "_rom_do"},     bus.rom_do,     0);
    check({tag, "_rom_wr"},     bus.rom_wr,     0);
    check({tag, "_rom_rd"},     bus.rom_rd,     0);
    check({tag, "_core_reset"}, bus.core_reset, 1);
    check({tag, "_load_done"},  bus.load_done,  0);
    check({tag, "_byte_count"}, bus.byte_count, 0);
    check({tag, "_ioctl_wait"}, bus.ioctl_wait, 0);
    check({tag, "_addr_err"},   bus.addr_err,   0);
    check({tag, "_overflow"},   bus.overflow,   0);
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_nwrites"}, cap_q.size(), n);
    for (int k = 0; k < n && k < cap_q.size() && k < drv_q.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), cap_q[k].a, drv_q[k].a);
      check($sformatf("%s_data%0d", tag, k), cap_q[k].d, drv_q[k].d);
    end
  endtask

  task automatic push_byte(input logic [16:0] a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    drv_q.push_back('{a, d});
  endtask

  task automatic run_load(input int v, input logic [7:0] idx, input int nbytes,
                          input int skip_at, input int ce_load, input bit honour,
                          output logic rd_mid);
    int          i;
    int          guard;
    logic [16:0] a;
    ce_period = ce_load;
    @(negedge clk_sys);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
    repeat (2) @(negedge clk_sys);
    rd_mid = bus.rom_rd;
    i = 0;
    guard = 0;
    while (i < nbytes) begin
      if (honour && bus.ioctl_wait) begin
        bus.ioctl_wr = 1'b0;
        guard++;
        if (guard > 100) begin
          timeout_fail($sformatf("wait_release_v%0d", v));
          break;
        end
      end else begin
        a = (skip_at >= 0 && i >= skip_at) ? 17'(i + 1) : 17'(i);
        push_byte(a, 8'(a * 13 + v * 31 + 1));
        i++;
        guard = 0;
      end
      @(negedge clk_sys);
    end
    bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk_sys);
      #1;
      if (bus.load_done) break;
      n++;
    end
    if (n >= 3000) timeout_fail({tag, "_load_done"});
  endtask

  initial begin
    logic rd_mid;
    int   n;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    reset_n = 1'b0;

    //          idx    n  skip ceL ceA hon  wr  rd    done  err   chk ovf
    vecs[0] = '{8'd1,  8, -1,  4,  4,  1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'd0, 16, -1,  4,  4,  1'b1, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'd0, 64, -1,  8,  8,  1'b1, 64, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'd0,  6, -1,  0,  4,  1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'd0,  3,  2,  4,  4,  1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk_sys);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      drv_q.delete();
      cap_q.delete();
      run_load(v, vecs[v].index, vecs[v].nbytes, vecs[v].skip_at,
               vecs[v].ce_load, vecs[v].honour, rd_mid);
      ce_period = vecs[v].ce_after;
      if (vecs[v].exp_done) wait_done(tag);
      else begin
        repeat (40) @(posedge clk_sys);
        #1;
      end
      check({tag, "_rom_rd_mid"}, rd_mid,             vecs[v].exp_rd);
      check({tag, "_load_done"},  bus.load_done,      vecs[v].exp_done);
      check({tag, "_core_reset"}, bus.core_reset,     !vecs[v].exp_done);
      check({tag, "_rom_rd_end"}, bus.rom_rd,         0);
      check({tag, "_byte_count"}, bus.byte_count,     vecs[v].exp_writes);
      check({tag, "_overflow"},   bus.overflow,       vecs[v].exp_ovf);
      if (vecs[v].chk_err) check({tag, "_addr_err"}, bus.addr_err, vecs[v].exp_err);
      check_writes(tag, vecs[v].exp_writes);
    end

    // ioctl_wait threshold: with no core strobe it rises on the push that makes occupancy 3
    drv_q.delete();
    cap_q.delete();
    ce_period = 0;
    @(negedge clk_sys);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    repeat (2) @(negedge clk_sys);
    for (int k = 0; k < 3; k++) begin
      push_byte(17'(k), 8'(8'hC0 + k));
      @(posedge clk_sys);
      #1;
      check($sformatf("wait_after_push%0d", k), bus.ioctl_wait, (k == 2));
      @(negedge clk_sys);
    end
    bus.ioctl_wr = 1'b0;
    ce_period = 2;
    n = 0;
    while (bus.ioctl_wait && n < 20) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    check("wait_released", bus.ioctl_wait, 0);
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
    wait_done("thresh");
    check("thresh_byte_count", bus.byte_count, 3);
    check("thresh_overflow", bus.overflow, 0);
    check_writes("thresh", 3);

    // reset mid-load with two bytes buffered, then a fresh download
    drv_q.delete();
    cap_q.delete();
    ce_period = 0;
    @(negedge clk_sys);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    repeat (2) @(negedge clk_sys);
    push_byte(17'd5, 8'h55);
    @(negedge clk_sys);
    push_byte(17'd6, 8'h66);
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    check("premid_addr_err", bus.addr_err, 1);
    check("premid_rom_rd", bus.rom_rd, 1);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    drv_q.delete();
    cap_q.delete();
    repeat (2) @(negedge clk_sys);
    run_load(9, 8'd0, 4, -1, 4, 1'b1, rd_mid);
    wait_done("recover");
    check("recover_byte_count", bus.byte_count, 4);
    check("recover_core_reset", bus.core_reset, 0);
    check("recover_addr_err", bus.addr_err, 0);
    check_writes("recover", 4);

    check("slot_timing_errors", slot_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
